// File: rtl/btn_debounce_one_shot.sv
// Button debouncer: four-state stable-window FSM driving a registered level and a retriggerable rising-edge one-shot.
// Optional feature macro DB_SYNC_EN adds a two-flop input synchronizer ahead of the FSM.
module btn_debounce_one_shot #(
  parameter int DEBOUNCE_CNT = 100000,
  parameter int PULSE_LEN    = 3
) (
  input  logic clk,
  input  logic RST,
  input  logic btn_in,
  output logic db_out,
  output logic pos_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CNT);
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] CNT_TERM   = CW'(DEBOUNCE_CNT - 1);
  localparam logic [PW-1:0] PULSE_INIT = PW'(PULSE_LEN);

  typedef enum logic [1:0] {LOW, CHK_HI, HIGH, CHK_LO} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   pulse_cnt_q;
  logic            db_q;
  logic            pulse_q;
  logic            s;

`ifdef DB_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = btn_in;
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= LOW;
      cnt_q       <= '0;
      pulse_cnt_q <= '0;
      db_q        <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      // One-shot countdown; a debounced rise below reloads it, so pulses restart rather than stack.
      if (pulse_cnt_q != '0) pulse_cnt_q <= pulse_cnt_q - 1'b1;
      pulse_q <= (pulse_cnt_q > PW'(1));

      case (state_q)
        LOW: begin
          if (s) begin
            state_q <= CHK_HI;
            cnt_q   <= CW'(1);
          end else begin
            cnt_q   <= '0;
          end
          db_q <= 1'b0;
        end
        CHK_HI: begin
          if (!s) begin
            state_q <= LOW;
            cnt_q   <= '0;
            db_q    <= 1'b0;
          end else if (cnt_q == CNT_TERM) begin
            state_q     <= HIGH;
            cnt_q       <= '0;
            db_q        <= 1'b1;
            pulse_cnt_q <= PULSE_INIT;
            pulse_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            db_q  <= 1'b0;
          end
        end
        HIGH: begin
          if (!s) begin
            state_q <= CHK_LO;
            cnt_q   <= CW'(1);
          end else begin
            cnt_q   <= '0;
          end
          db_q <= 1'b1;
        end
        CHK_LO: begin
          if (s) begin
            state_q <= HIGH;
            cnt_q   <= '0;
            db_q    <= 1'b1;
          end else if (cnt_q == CNT_TERM) begin
            state_q <= LOW;
            cnt_q   <= '0;
            db_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            db_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= LOW;
          cnt_q   <= '0;
          db_q    <= 1'b0;
        end
      endcase
    end
  end

  assign db_out    = db_q;
  assign pos_pulse = pulse_q;

endmodule

// File: tb/tb_btn_debounce_one_shot.sv
// Scoreboard bench: two debouncers (PULSE_LEN 3 and 20) share directed stimulus; a monitor checks every cycle.
module tb_btn_debounce_one_shot;

`ifdef DB_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif
  localparam int NSCN = 6;
  localparam int SLEN = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic btn = 1'b0;
  logic db_a, pp_a, db_b, pp_b;

  btn_debounce_one_shot #(.DEBOUNCE_CNT(4), .PULSE_LEN(3)) dut_a (
    .clk(clk), .RST(rst), .btn_in(btn), .db_out(db_a), .pos_pulse(pp_a));

  btn_debounce_one_shot #(.DEBOUNCE_CNT(4), .PULSE_LEN(20)) dut_b (
    .clk(clk), .RST(rst), .btn_in(btn), .db_out(db_b), .pos_pulse(pp_b));

  typedef struct {
    int   scn;
    int   t;
    logic db;
    logic ppa;
    logic ppb;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic win(input int t, input int r, input int len);
    return (t >= r + L) && (t < r + L + len);
  endfunction

  // Hand-computed stimulus and expected debounced level / rise cycles per scenario (cycle t of scenario).
  task automatic gen(input int scn, input int t, output logic r, output logic b,
                     output logic db, output int r0, output int r1);
    r  = (t < 2);
    b  = 1'b0;
    db = 1'b0;
    r0 = -1000;
    r1 = -1000;
    case (scn)
      0: begin  // clean press
        b = (t >= 10); db = (t >= 14 + L); r0 = 14;
      end
      1: begin  // bounce 1,1,0,1,1,1,1
        b = (t >= 10) && (t != 12); db = (t >= 17 + L); r0 = 17;
      end
      2: begin  // release with one-cycle glitch
        b = ((t >= 10) && (t < 30)) || (t == 32);
        db = (t >= 14 + L) && (t < 37 + L); r0 = 14;
      end
      3: begin  // reset mid-check
        b = (t >= 10); r = (t < 2) || (t == 12);
        db = (t >= 17 + L); r0 = 17;
      end
      4: begin  // press, release, press: retrigger
        b = ((t >= 10) && (t < 15)) || (t >= 20);
        db = ((t >= 14 + L) && (t < 19 + L)) || (t >= 24 + L); r0 = 14; r1 = 24;
      end
      default: begin  // fall while long pulse active
        b = (t >= 10) && (t < 16);
        db = (t >= 14 + L) && (t < 20 + L); r0 = 14;
      end
    endcase
  endtask

  task automatic chk(input string name, input int scn, input int t, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s scn=%0d t=%0d got=%b expected=%b", name, scn, t, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("db_a", e.scn, e.t, db_a, e.db);
      chk("pp_a", e.scn, e.t, pp_a, e.ppa);
      chk("db_b", e.scn, e.t, db_b, e.db);
      chk("pp_b", e.scn, e.t, pp_b, e.ppb);
    end
  end

  initial begin
    logic r, b, db;
    int   r0, r1;
    exp_t e;
    for (int scn = 0; scn < NSCN; scn++) begin
      for (int t = 0; t < SLEN; t++) begin
        @(posedge clk);
        #1;
        gen(scn, t, r, b, db, r0, r1);
        rst = r;
        btn = b;
        if (t >= 1) begin
          e.scn = scn;
          e.t   = t;
          e.db  = db;
          e.ppa = win(t, r0, 3) || win(t, r1, 3);
          e.ppb = win(t, r0, 20) || win(t, r1, 20);
          sb_q.push_back(e);
        end
      end
      $display("scenario %0d: %0d cycles issued", scn, SLEN);
    end
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce_one_shot.md
BTN_DEBOUNCE_ONE_SHOT -- requirements
Module: btn_debounce_one_shot

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 100000: consecutive stable-sample cycles needed to accept a new level (2 ms at 50 MHz s_clk); legal range 2..2^20.
REQ-002 Parameter PULSE_LEN, default 3: length in cycles of the rising-edge one-shot; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge (connected to the divided s_clk).
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 btn_in  input  1  raw, bouncing, asynchronous button level (e.g. board button 4).
REQ-006 db_out  output  1  debounced button level, registered.
REQ-007 pos_pulse  output  1  registered one-shot on each debounced rising edge; drives the MCU intr input.

Function
REQ-008 Sample s SHALL be the synchronizer output (see Configuration); the FSM SHALL operate only on s.
REQ-009 FSM states: LOW, CHK_HI, HIGH, CHK_LO; db_out SHALL be 1 exactly when state is HIGH or CHK_LO.
REQ-010 LOW: s=1 -> CHK_HI with cnt<=1; s=0 -> stay, cnt<=0.
REQ-011 CHK_HI: s=0 -> LOW, cnt<=0; s=1 and cnt==DEBOUNCE_CNT-1 -> HIGH, cnt<=0; otherwise cnt<=cnt+1.
REQ-012 HIGH: s=0 -> CHK_LO with cnt<=1; s=1 -> stay, cnt<=0.
REQ-013 CHK_LO: s=1 -> HIGH, cnt<=0; s=0 and cnt==DEBOUNCE_CNT-1 -> LOW, cnt<=0; otherwise cnt<=cnt+1.
REQ-014 Latency: if s is 1 in cycles k..k+DEBOUNCE_CNT-1 starting from LOW, db_out SHALL first be 1 in cycle k+DEBOUNCE_CNT; falling is symmetric.
REQ-015 Any bounce (s toggle) inside a CHK state SHALL abort the check, restoring the prior state with no change on db_out.
REQ-016 cnt width SHALL be $clog2(DEBOUNCE_CNT); it SHALL never wrap, since it is cleared at the terminal value.
REQ-017 On the CHK_HI->HIGH transition, pos_pulse SHALL be 1 starting in the same cycle db_out rises and stay 1 for exactly PULSE_LEN cycles.
REQ-018 A new debounced rise while pos_pulse is active SHALL restart the pulse counter, giving PULSE_LEN cycles from the new rise; pulses SHALL not accumulate.
REQ-019 A debounced fall SHALL NOT truncate an active pulse; no pulse SHALL be produced on falling edges.

Reset
REQ-020 RST=1 at a clock edge SHALL force state LOW, cnt 0, pulse counter 0, synchronizer flops 0, db_out 0 and pos_pulse 0 in the following cycle.
REQ-021 Reset mid-check or mid-pulse SHALL abandon the operation; after release the FSM SHALL require a full DEBOUNCE_CNT stable window, even if btn_in has stayed high.
REQ-022 RST SHALL have priority over every other event in the same cycle.

Configuration
REQ-023 Macro DB_SYNC_EN defined: btn_in SHALL pass through a two-flop synchronizer, making s equal to btn_in delayed 2 cycles (total rise latency DEBOUNCE_CNT+2 from btn_in).
REQ-024 Macro DB_SYNC_EN undefined: s SHALL equal btn_in directly (for benches and for inputs already synchronous to clk); all other behaviour is unchanged.

Verification (DEBOUNCE_CNT=4, PULSE_LEN=3, DB_SYNC_EN undefined unless noted)
REQ-025 Clean press: btn_in 0->1 at cycle 10 and held -> db_out=1 from cycle 14; pos_pulse=1 in cycles 14,15,16 only.
REQ-026 Bounce: btn_in pattern 1,1,0,1,1,1,1 from cycle 10 -> db_out stays 0 until cycle 17; exactly one 3-cycle pulse, at 17-19.
REQ-027 Release: from HIGH, btn_in=0 at cycle 30 with a 1-cycle glitch high at 32 -> db_out falls at cycle 37; no pulse.
REQ-028 Reset mid-check: btn_in high from cycle 10, RST=1 in cycle 12 only -> outputs 0 at 13; db_out=1 at cycle 17 (new window 13-16).
REQ-029 Retrigger: PULSE_LEN=20; press, release, press, each stable 5 cycles -> second debounced rise restarts the pulse; pos_pulse stays 1 for 20 cycles after the second rise.
REQ-030 DB_SYNC_EN defined: clean press at cycle 10 -> db_out=1 from cycle 16; pos_pulse=1 in cycles 16-18.
